// File: rtl/uart_rx.sv
// uart_rx -- UART receiver with an 8-entry asynchronous receive FIFO.
//
// The serial line is oversampled on sck, each 11-bit character
// (start, 8 data LSB first, even parity, stop) is deframed, and good bytes
// are pushed into the FIFO. The system side pops bytes on clk.
//
// Optional feature: define UART_RX_PARITY_CHECK_EN to drop bytes whose
// parity slot mismatches and raise parity_err_o. When it is undefined the
// parity slot is sampled for timing only and parity_err_o is tied low.
//
// Ports:
//   clk            system clock, FIFO read side
//   rst_n          asynchronous active-low reset (both domains)
//   sck            sample clock (OVERSAMPLE x baud), receiver + FIFO write side
//   rx_d_i         serial line, idle high
//   rx_rts_n_o     low = ready to receive (registered on sck)
//   rx_enable_i    receive enable for SIMPLEX/HALFDUPLEX
//   rx_d_o         FIFO head byte (clk domain)
//   rx_d_valid_o   FIFO not empty (clk domain)
//   rx_d_ready_i   pop request (clk domain)
//   rx_full_o      FIFO full (sck domain)
//   rx_empty_o     FIFO empty (clk domain)
//   parity_err_o, frame_err_o, overrun_err_o  sticky error flags (sck domain)
//   uart_config_i  mode / master / flush_rx

package uart_pkg;
    typedef enum logic [1:0] {
        FULLDUPLEX = 2'd0,
        HALFDUPLEX = 2'd1,
        SIMPLEX    = 2'd2
    } uart_mode_t;

    typedef struct packed {
        uart_mode_t mode;
        logic       master;
        logic       flush_rx;
    } Config_t;
endpackage

module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       rx_d_i,
    output logic       rx_rts_n_o,
    input  logic       rx_enable_i,
    output logic [7:0] rx_d_o,
    output logic       rx_d_valid_o,
    input  logic       rx_d_ready_i,
    output logic       rx_full_o,
    output logic       rx_empty_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overrun_err_o,
    input  Config_t    uart_config_i
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    // ------------------------------------------------------------------
    // Line synchronizer and control decode
    // ------------------------------------------------------------------
    logic rx_meta, rxs;

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_d_i;
            rxs     <= rx_meta;
        end
    end

    logic enabled, flush;
    assign enabled = (uart_config_i.mode == FULLDUPLEX) || rx_enable_i;
    assign flush   = uart_config_i.flush_rx ||
                     ((uart_config_i.mode == SIMPLEX) && uart_config_i.master);

    // ------------------------------------------------------------------
    // Receiver FSM and datapath
    // ------------------------------------------------------------------
    rx_state_t     state, state_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic [2:0]    bcnt, bcnt_d;
    logic [7:0]    shreg, shreg_d;
    logic          enq_set, ferr_set, oerr_set;
    logic          enq_valid;
    logic [7:0]    enq_data;
    logic          full, ferr_q, oerr_q;
    logic          parity_bad;

`ifdef UART_RX_PARITY_CHECK_EN
    logic par_bit, par_bit_d, perr_set, perr_q;
    assign parity_bad = (par_bit != ^shreg);
`else
    assign parity_bad = 1'b0;
`endif

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
            tcnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
        end else begin
            state <= state_d;
            tcnt  <= tcnt_d;
            bcnt  <= bcnt_d;
            shreg <= shreg_d;
        end
    end

    always_comb begin
        state_d  = state;
        tcnt_d   = (tcnt == T_END) ? '0 : tcnt + TW'(1);
        bcnt_d   = bcnt;
        shreg_d  = shreg;
        enq_set  = 1'b0;
        ferr_set = 1'b0;
        oerr_set = 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
        par_bit_d = par_bit;
        perr_set  = 1'b0;
`endif
        case (state)
            RX_IDLE: begin
                tcnt_d = '0;
                if (enabled && !rxs) state_d = RX_START;
            end
            RX_START: begin
                if (tcnt == T_MID) begin
                    if (rxs) begin
                        state_d = RX_IDLE;
                    end else begin
                        // Re-centre: from here on every T_END is mid-bit.
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                        state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (tcnt == T_END) begin
                    shreg_d = {rxs, shreg[7:1]};
                    bcnt_d  = bcnt + 3'd1;
                    if (bcnt == 3'd7) state_d = RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (tcnt == T_END) begin
`ifdef UART_RX_PARITY_CHECK_EN
                    par_bit_d = rxs;
`endif
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tcnt == T_END) begin
                    state_d = RX_IDLE;
                    if (!rxs) begin
                        ferr_set = 1'b1;
                        state_d  = RX_BREAK;
                    end else if (parity_bad) begin
`ifdef UART_RX_PARITY_CHECK_EN
                        perr_set = 1'b1;
`endif
                    end else if (full) begin
                        oerr_set = 1'b1;
                    end else begin
                        enq_set = 1'b1;
                    end
                end
            end
            RX_BREAK: begin
                tcnt_d = '0;
                if (rxs) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase

        if (flush) begin
            state_d  = RX_IDLE;
            enq_set  = 1'b0;
            ferr_set = 1'b0;
            oerr_set = 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
            perr_set = 1'b0;
`endif
        end
    end

`ifdef UART_RX_PARITY_CHECK_EN
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            par_bit <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            par_bit <= par_bit_d;
            if (flush)         perr_q <= 1'b0;
            else if (perr_set) perr_q <= 1'b1;
        end
    end
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            enq_valid  <= 1'b0;
            enq_data   <= '0;
            ferr_q     <= 1'b0;
            oerr_q     <= 1'b0;
            rx_rts_n_o <= 1'b1;
        end else begin
            enq_valid  <= enq_set;
            enq_data   <= shreg;
            rx_rts_n_o <= !(enabled && !full && !flush);
            if (flush) begin
                ferr_q <= 1'b0;
                oerr_q <= 1'b0;
            end else begin
                if (ferr_set) ferr_q <= 1'b1;
                if (oerr_set) oerr_q <= 1'b1;
            end
        end
    end

    assign frame_err_o   = ferr_q;
    assign overrun_err_o = oerr_q;

    // ------------------------------------------------------------------
    // Asynchronous FIFO, 8 entries, Gray-coded pointers
    // ------------------------------------------------------------------
    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b = '0;
        for (int unsigned i = 0; i < 4; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    logic [7:0] mem [8];
    logic [3:0] wbin, wgray, rq1, rq2;
    logic [3:0] rbin, rgray, wq1, wq2;
    logic [3:0] wbin_n, rbin_n;
    logic       wr_en, rd_en, empty;
    logic       flush_q, fq1, fq2;

    // A flush arriving together with the pending enqueue drops the byte.
    assign wr_en  = enq_valid && !flush && !full;
    assign wbin_n = wbin + 4'd1;
    assign full   = (wgray == {~rq2[3:2], rq2[1:0]});

    always_ff @(posedge sck) begin
        if (wr_en) mem[wbin[2:0]] <= enq_data;
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            wbin    <= '0;
            wgray   <= '0;
            rq1     <= '0;
            rq2     <= '0;
            flush_q <= 1'b0;
        end else begin
            rq1     <= rgray;
            rq2     <= rq1;
            flush_q <= flush;
            if (wr_en) begin
                wbin  <= wbin_n;
                wgray <= wbin_n ^ (wbin_n >> 1);
            end
        end
    end

    assign empty  = (rgray == wq2);
    assign rd_en  = !empty && rx_d_ready_i;
    assign rbin_n = rbin + 4'd1;

    // Flush is performed on the read side: the read pointer is snapped to
    // the synchronized write pointer, which the write side holds still
    // because the receiver cannot enqueue while flushing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbin  <= '0;
            rgray <= '0;
            wq1   <= '0;
            wq2   <= '0;
            fq1   <= 1'b0;
            fq2   <= 1'b0;
        end else begin
            wq1 <= wgray;
            wq2 <= wq1;
            fq1 <= flush_q;
            fq2 <= fq1;
            if (fq2) begin
                rbin  <= gray2bin(wq2);
                rgray <= wq2;
            end else if (rd_en) begin
                rbin  <= rbin_n;
                rgray <= rbin_n ^ (rbin_n >> 1);
            end
        end
    end

    assign rx_d_o       = mem[rbin[2:0]];
    assign rx_d_valid_o = !empty;
    assign rx_empty_o   = empty;
    assign rx_full_o    = full;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: a behavioural line driver sends framed characters
// and a frame-level reference model predicts received bytes and error flags.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned OS = 16;
`ifdef UART_RX_PARITY_CHECK_EN
    localparam bit PAR_CHK = 1'b1;
`else
    localparam bit PAR_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       sck = 1'b0;
    logic       rst_n;
    logic       rx_d_i;
    logic       rx_rts_n_o;
    logic       rx_enable_i;
    logic [7:0] rx_d_o;
    logic       rx_d_valid_o;
    logic       rx_d_ready_i;
    logic       rx_full_o;
    logic       rx_empty_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       overrun_err_o;
    Config_t    cfg;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    bit exp_perr, exp_ferr, exp_oerr;

    always #5 sck = ~sck;
    always #7 clk = ~clk;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sck          (sck),
        .rx_d_i       (rx_d_i),
        .rx_rts_n_o   (rx_rts_n_o),
        .rx_enable_i  (rx_enable_i),
        .rx_d_o       (rx_d_o),
        .rx_d_valid_o (rx_d_valid_o),
        .rx_d_ready_i (rx_d_ready_i),
        .rx_full_o    (rx_full_o),
        .rx_empty_o   (rx_empty_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .overrun_err_o(overrun_err_o),
        .uart_config_i(cfg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pop monitor: every byte leaving the FIFO must be the next predicted one.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_d_valid_o && rx_d_ready_i) begin
                if (exp_q.size() == 0)
                    check("pop_extra", 32'(rx_d_valid_o), 32'd0);
                else
                    check("pop_data", 32'(rx_d_o), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_bit(input logic b);
        rx_d_i = b;
        repeat (OS) @(negedge sck);
    endtask

    // Frame-level model: decides the fate of a character from its framing
    // errors and the predicted FIFO occupancy.
    task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        if (bad_stop)                 exp_ferr = 1'b1;
        else if (PAR_CHK && bad_par)  exp_perr = 1'b1;
        else if (exp_q.size() >= 8)   exp_oerr = 1'b1;
        else                          exp_q.push_back(d);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input int extra_low, input bit accepted);
        @(negedge sck);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((^d) ^ bad_par);
        // Predict before the stop bit so the monitor already knows the byte.
        if (accepted) model_frame(d, bad_par, bad_stop);
        send_bit(!bad_stop);
        for (int i = 0; i < extra_low; i++) send_bit(1'b0);
        rx_d_i = 1'b1;
    endtask

    task automatic check_flags();
        repeat (4) @(negedge sck);
        check("parity_err", 32'(parity_err_o), 32'(exp_perr));
        check("frame_err", 32'(frame_err_o), 32'(exp_ferr));
        check("overrun_err", 32'(overrun_err_o), 32'(exp_oerr));
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_flush();
        drain();
        cfg.flush_rx = 1'b1;
        repeat (6) @(negedge clk);
        cfg.flush_rx = 1'b0;
        repeat (6) @(negedge clk);
        exp_perr = 1'b0;
        exp_ferr = 1'b0;
        exp_oerr = 1'b0;
        check("flush_empty", 32'(rx_empty_o), 32'd1);
        check("flush_valid", 32'(rx_d_valid_o), 32'd0);
        check_flags();
    endtask

    task automatic check_reset_values();
        check("rst_rts", 32'(rx_rts_n_o), 32'd1);
        check("rst_valid", 32'(rx_d_valid_o), 32'd0);
        check("rst_empty", 32'(rx_empty_o), 32'd1);
        check("rst_full", 32'(rx_full_o), 32'd0);
        check("rst_perr", 32'(parity_err_o), 32'd0);
        check("rst_ferr", 32'(frame_err_o), 32'd0);
        check("rst_oerr", 32'(overrun_err_o), 32'd0);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 rx_d_ready_i = r;
    endtask

    initial begin
        rx_d_i       = 1'b1;
        rst_n        = 1'b0;
        rx_enable_i  = 1'b0;
        rx_d_ready_i = 1'b1;
        cfg          = '{mode: FULLDUPLEX, master: 1'b0, flush_rx: 1'b0};
        exp_perr     = 1'b0;
        exp_ferr     = 1'b0;
        exp_oerr     = 1'b0;

        repeat (3) @(negedge sck);
        check_reset_values();
        rst_n = 1'b1;
        repeat (4) @(negedge sck);
        check("rts_ready", 32'(rx_rts_n_o), 32'd0);

        // Back-to-back characters
        send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b1);
        drain();
        check_flags();

        // Start glitch followed by a real character
        @(negedge sck);
        rx_d_i = 1'b0;
        repeat (4) @(negedge sck);
        rx_d_i = 1'b1;
        repeat (2 * OS) @(negedge sck);
        check("glitch_empty", 32'(rx_empty_o), 32'd1);
        send_frame(8'h55, 1'b0, 1'b0, 0, 1'b1);
        drain();
        check_flags();

        // Inverted parity slot
        send_frame(8'h81, 1'b1, 1'b0, 0, 1'b1);
        drain();
        check_flags();
        check("par_empty", 32'(rx_empty_o), 32'd1);
        do_flush();

        // Framing error followed by a long break, then a good character
        send_frame(8'h7E, 1'b0, 1'b1, 40, 1'b1);
        repeat (2 * OS) @(negedge sck);
        send_frame(8'h11, 1'b0, 1'b0, 0, 1'b1);
        drain();
        check_flags();
        do_flush();

        // FIFO fill and overrun with the reader stalled
        set_ready(1'b0);
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 0, 1'b1);
            repeat (4) @(negedge sck);
            if (i == 6) check("rts_not_full", 32'(rx_rts_n_o), 32'd0);
            if (i == 7) begin
                check("rts_full", 32'(rx_rts_n_o), 32'd1);
                check("fifo_full", 32'(rx_full_o), 32'd1);
            end
        end
        check_flags();
        set_ready(1'b1);
        drain();
        do_flush();

        // Enable gating and flush by SIMPLEX master
        cfg.mode    = SIMPLEX;
        rx_enable_i = 1'b0;
        repeat (4) @(negedge sck);
        check("rts_disabled", 32'(rx_rts_n_o), 32'd1);
        send_frame(8'h5A, 1'b0, 1'b0, 0, 1'b0);
        repeat (2 * OS) @(negedge sck);
        check("disabled_empty", 32'(rx_empty_o), 32'd1);
        cfg.mode    = HALFDUPLEX;
        rx_enable_i = 1'b1;
        send_frame(8'hC3, 1'b0, 1'b0, 0, 1'b1);
        drain();
        cfg.mode   = SIMPLEX;
        cfg.master = 1'b1;
        repeat (4) @(negedge sck);
        check("rts_simplex_master", 32'(rx_rts_n_o), 32'd1);
        cfg        = '{mode: FULLDUPLEX, master: 1'b0, flush_rx: 1'b0};
        rx_enable_i = 1'b0;
        repeat (8) @(negedge clk);

        // Reset in the middle of a character
        @(negedge sck);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rst_n  = 1'b0;
        rx_d_i = 1'b1;
        repeat (3) @(negedge sck);
        check_reset_values();
        rst_n = 1'b1;
        repeat (2 * OS) @(negedge sck);
        send_frame(8'h0F, 1'b0, 1'b0, 0, 1'b1);
        drain();
        check_flags();

        // Randomized characters, errors and gaps
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            bit bp, bs;
            d  = 8'($urandom);
            bp = ($urandom_range(0, 7) == 0);
            bs = ($urandom_range(0, 9) == 0);
            send_frame(d, bp, bs, 0, 1'b1);
            check_flags();
            if (exp_perr || exp_ferr || exp_oerr) do_flush();
            repeat ($urandom_range(0, 40)) @(negedge sck);
        end
        drain();
        check("final_empty", 32'(rx_empty_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver; the receive-side counterpart of `uart_tx` in the UART block. It oversamples the serial line on the sample clock `sck`, deframes each 11-bit character, checks even parity and the stop bit, and pushes good bytes into an 8-entry `fifo_async` that the system side reads on `clk`. It drives `rx_rts_n_o`, which the peer transmitter samples as its CTS.

## Interface
- `OVERSAMPLE`, default 16: `sck` ticks per bit; even, ≥ 4.
- `clk` in 1: system clock; FIFO dequeue side.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sck` in 1: sample clock at `OVERSAMPLE` × baud; FIFO enqueue side; all receiver logic runs on it.
- `rx_d_i` in 1: serial line, idle high.
- `rx_rts_n_o` out 1: low means ready to receive.
- `rx_enable_i` in 1: receive enable; used only in SIMPLEX/HALFDUPLEX.
- `rx_d_o` out 8: FIFO head byte (`clk` domain).
- `rx_d_valid_o` out 1: FIFO not empty.
- `rx_d_ready_i` in 1: pop FIFO on `clk` when valid && ready.
- `rx_full_o`, `rx_empty_o` out 1 each: FIFO status.
- `parity_err_o`, `frame_err_o`, `overrun_err_o` out 1 each: sticky error flags (`sck` domain).
- `uart_config_i` in `Config_t`: uses `mode`, `master`, `flush_rx`.

## Operation
- Input: `rx_d_i` passes through a 2-flop synchronizer on `sck`; the output is `rxs`.
- Enabled = (`mode` == FULLDUPLEX) || `rx_enable_i`.
- Flush = `flush_rx` || (`mode` == SIMPLEX && `master`).
- Frame, in line order: start 0, `data[0]`..`data[7]` (LSB first), parity = XOR of `data[7:0]`, stop 1.
- Counters: tick counter `tcnt` of width clog2(`OVERSAMPLE`); bit counter `bcnt` of width 3.
- Flush empties the FIFO, clears the error flags and forces RX_IDLE.
- RX_IDLE:
  - Goes to RX_START when enabled && `rxs` == 0.
  - On entry to RX_START, `tcnt` = 0.
- RX_START:
  - At `tcnt` == `OVERSAMPLE`/2 − 1 (mid-bit), resample `rxs`.
  - If `rxs` == 1 (glitch), return to RX_IDLE; no flag is set.
  - If `rxs` == 0, clear `tcnt` and `bcnt` and go to RX_DATA.
- RX_DATA:
  - At `tcnt` == `OVERSAMPLE` − 1, shift `rxs` into `shreg[7]` (right shift) and increment `bcnt`.
  - After the 8th sample (`bcnt` wraps 7→0), go to RX_PARITY.
- RX_PARITY: at the mid-bit sample, latch `par_bit`, then go to RX_STOP.
- RX_STOP, at the mid-bit sample:
  - Stop bit == 0: set `frame_err_o`, discard the byte, go to RX_BREAK.
  - Else, with parity mismatch (see Configuration): set `parity_err_o`, discard the byte, go to RX_IDLE.
  - Else, FIFO full: set `overrun_err_o`, discard the byte, go to RX_IDLE.
  - Else: assert `enq_valid` for 1 `sck` cycle with `shreg`, go to RX_IDLE.
- RX_BREAK: wait until `rxs` == 1, then go to RX_IDLE. A held-low line (break) therefore produces exactly one framing error.
- Undefined state: go to RX_IDLE.
- Enable deasserted mid-frame: the current frame completes; only the IDLE→START transition is gated.
- `rx_rts_n_o` (registered on `sck`) = !(enabled && !`rx_full_o` && !flush).

## Timing
- Reset values:
  - State RX_IDLE; `tcnt`, `bcnt` and `shreg` = 0.
  - `rx_rts_n_o` = 1; all error flags = 0.
  - FIFO empty, so `rx_d_valid_o` = 0, `rx_empty_o` = 1, `rx_full_o` = 0.
- Start detection:
  - Up to 2 `sck` cycles of synchronizer delay.
  - Then up to 1 tick of edge quantization.
- Samples fall at tick `OVERSAMPLE`/2 − 1 of each bit, measured from the start-edge detection.
- Enqueue happens in the `sck` cycle after the stop-bit sample.
- `rx_d_valid_o` rises per the `fifo_async` CDC latency (≤ 3 `clk` cycles after the enqueue).
- Pop: `rx_d_o` updates the `clk` cycle after a pop.
- Back-to-back frames: a new start bit may begin from the stop-bit mid-sample onward; it is accepted without a gap.
- Error flags set in the cycle after the deciding sample. They hold until flush or reset.
- Simultaneous enqueue and flush: flush wins; the byte is lost; no overrun is flagged.
- `rst_n` mid-frame: the partial frame is abandoned. After release the receiver waits in RX_IDLE; if the line is low, RX_START begins at the next edge detection.

## Configuration
- `UART_RX_PARITY_CHECK_EN` defined:
  - Mismatch = `par_bit` != ^`shreg`.
  - A mismatching byte is dropped and `parity_err_o` is set.
- Not defined:
  - The parity slot is still sampled for timing but ignored.
  - `parity_err_o` is tied to 0; the byte is enqueued regardless.

## Test plan
- FULLDUPLEX, `OVERSAMPLE`=16, line driven by `uart_tx` sending 0xA5, 0x3C → `rx_d_o` pops 0xA5 then 0x3C; no error flags.
- Start glitch (line low for 4 `sck` ticks), then 0x55 → glitch ignored; 0x55 received; no errors.
- Frame 0x81 with the parity bit inverted:
  - Macro defined → FIFO empty, `parity_err_o`=1.
  - Macro undefined → 0x81 enqueued, flag stays 0.
- Stop bit forced to 0 on 0x7E, line held low for 40 bits, then idle, then 0x11 → `frame_err_o`=1; only 0x11 enqueued.
- `rx_d_ready_i`=0, send 9 bytes 0x00..0x08:
  - `rx_rts_n_o` goes 1 after the 8th byte.
  - 9th byte dropped, `overrun_err_o`=1.
  - Pops return 0x00..0x07.
- Assert `rst_n`=0 mid-data of 0xF0, release, send 0x0F → only 0x0F received. Pulse `flush_rx` → FIFO empty and flags cleared.
